// File: rtl/pc_sequencer.sv
// Next-PC generator with SPARC delayed control transfer, annul and trap redirect.
// Optional misaligned-target redirect is enabled with `define PC_SEQ_ALIGN_CHECK_EN.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_SEQ_ALIGN_CHECK_EN
   , parameter logic [31:0] MISALIGN_VECTOR = 32'h0000_0080
`endif
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] PC,
   input  logic        Advance,
   input  logic        Branch_Taken,
   input  logic [21:0] Branch_Disp,
   input  logic        Jump,
   input  logic [31:0] Jump_Target,
   input  logic        Annul,
   input  logic        Trap_Request,
   input  logic [31:0] Trap_Vector,
   output logic [31:0] PC_In,
   output logic        Load_Enable,
   output logic [31:0] nPC,
   output logic        Annul_Slot,
   output logic        Trap_Ack,
   output logic        Misalign
);

   typedef enum logic [1:0] {BOOT, RUN, TRAP_ISSUE} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_in_nxt, npc_nxt;
   logic        le_nxt, annul_nxt, ack_nxt, mis_nxt;
   logic [31:0] branch_target, raw_target;

   // Word displacement: sign-extend to 32 bits, then scale by 4.
   assign branch_target = PC + {{8{Branch_Disp[21]}}, Branch_Disp, 2'b00};
   assign raw_target    = Jump ? Jump_Target : branch_target;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nxt = state;
      pc_in_nxt = PC_In;
      npc_nxt   = nPC;
      le_nxt    = 1'b0;
      annul_nxt = Annul_Slot;
      ack_nxt   = 1'b0;
      mis_nxt   = 1'b0;

      case (state)
         BOOT: begin
            pc_in_nxt = RESET_VECTOR;
            npc_nxt   = RESET_VECTOR + 32'd4;
            le_nxt    = 1'b1;
            annul_nxt = 1'b0;
            state_nxt = RUN;
         end
         RUN: begin
            if (Trap_Request) begin
               pc_in_nxt = Trap_Vector;
               npc_nxt   = Trap_Vector + 32'd4;
               le_nxt    = 1'b1;
               ack_nxt   = 1'b1;
               annul_nxt = 1'b0;
               state_nxt = TRAP_ISSUE;
            end else if (Advance) begin
               // Delayed transfer: the old nPC (delay slot) is loaded first.
               pc_in_nxt = nPC;
               le_nxt    = 1'b1;
               annul_nxt = Annul & ~Branch_Taken;
               if (Jump || Branch_Taken) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
                  if (raw_target[1:0] != 2'b00) begin
                     npc_nxt = MISALIGN_VECTOR;
                     mis_nxt = 1'b1;
                  end else begin
                     npc_nxt = raw_target;
                  end
`else
                  npc_nxt = raw_target & 32'hFFFF_FFFC;
`endif
               end else begin
                  npc_nxt = nPC + 32'd4;
               end
            end
         end
         TRAP_ISSUE: state_nxt = RUN;
         default:    state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      if (Reset) begin
         state       <= BOOT;
         PC_In       <= 32'h0;
         nPC         <= 32'h0;
         Load_Enable <= 1'b0;
         Annul_Slot  <= 1'b0;
         Trap_Ack    <= 1'b0;
         Misalign    <= 1'b0;
      end else begin
         state       <= state_nxt;
         PC_In       <= pc_in_nxt;
         nPC         <= npc_nxt;
         Load_Enable <= le_nxt;
         Annul_Slot  <= annul_nxt;
         Trap_Ack    <= ack_nxt;
         Misalign    <= mis_nxt;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a behavioural next-PC model; honours PC_SEQ_ALIGN_CHECK_EN.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] MV = 32'h0000_0080;

   logic        Clock, Reset, Advance, Branch_Taken, Jump, Annul, Trap_Request;
   logic [31:0] PC, Jump_Target, Trap_Vector;
   logic [21:0] Branch_Disp;
   logic [31:0] PC_In, nPC;
   logic        Load_Enable, Annul_Slot, Trap_Ack, Misalign;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   logic [31:0] m_pc_in, m_npc;
   logic        m_le, m_annul, m_ack, m_mis;
   bit          m_booted, m_trap_hold;

   pc_sequencer dut (
      .Clock(Clock), .Reset(Reset), .PC(PC), .Advance(Advance),
      .Branch_Taken(Branch_Taken), .Branch_Disp(Branch_Disp), .Jump(Jump),
      .Jump_Target(Jump_Target), .Annul(Annul), .Trap_Request(Trap_Request),
      .Trap_Vector(Trap_Vector), .PC_In(PC_In), .Load_Enable(Load_Enable),
      .nPC(nPC), .Annul_Slot(Annul_Slot), .Trap_Ack(Trap_Ack), .Misalign(Misalign)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc_in = '0; m_npc = '0; m_le = 0; m_annul = 0; m_ack = 0; m_mis = 0;
      m_booted = 0; m_trap_hold = 0;
   endtask

   // One rising edge of the reference sequencer, evaluated from current inputs.
   task automatic model_edge();
      logic signed [31:0] disp;
      logic [31:0]        tgt;
      m_ack = 0; m_mis = 0; m_le = 0;
      if (!m_booted) begin
         m_booted = 1;
         m_pc_in  = RV;
         m_npc    = RV + 4;
         m_le     = 1;
      end else if (m_trap_hold) begin
         m_trap_hold = 0;
      end else if (Trap_Request) begin
         m_pc_in = Trap_Vector;
         m_npc   = Trap_Vector + 4;
         m_le    = 1;
         m_ack   = 1;
         m_annul = 0;
         m_trap_hold = 1;
      end else if (Advance) begin
         m_pc_in = m_npc;
         m_le    = 1;
         m_annul = Annul && !Branch_Taken;
         disp    = $signed(Branch_Disp);
         if (Jump)              tgt = Jump_Target;
         else                   tgt = PC + disp * 4;
         if (Jump || Branch_Taken) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            if (tgt % 4 != 0) begin
               m_npc = MV;
               m_mis = 1;
            end else begin
               m_npc = tgt;
            end
`else
            m_npc = tgt - (tgt % 4);
`endif
         end else begin
            m_npc = m_npc + 4;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc_in"}, PC_In, m_pc_in);
      check({tag, ".npc"},   nPC, m_npc);
      check({tag, ".le"},    32'(Load_Enable), 32'(m_le));
      check({tag, ".annul"}, 32'(Annul_Slot), 32'(m_annul));
      check({tag, ".ack"},   32'(Trap_Ack), 32'(m_ack));
      check({tag, ".mis"},   32'(Misalign), 32'(m_mis));
   endtask

   // Clock one edge, compare against the model, then emulate the PC register
   // capturing PC_In on the falling edge.
   task automatic step(input string tag);
      @(posedge Clock);
      model_edge();
      #1;
      check_all(tag);
      @(negedge Clock);
      if (m_le) PC = m_pc_in;
   endtask

   task automatic clear_ctl();
      Branch_Taken = 0; Jump = 0; Annul = 0; Trap_Request = 0;
   endtask

   initial begin
      Reset = 1; PC = '0; Advance = 0; Branch_Disp = '0; Jump_Target = '0;
      Trap_Vector = '0;
      clear_ctl();
      model_reset();
      #12;
      check_all("reset");
      @(negedge Clock);
      Reset = 0;

      // boot + sequential flow
      Advance = 1;
      step("boot");
      check("boot.pc_in_const", PC_In, 32'h0);
      step("seq1");
      check("seq1.pc_in_const", PC_In, 32'h4);
      step("seq2");
      check("seq2.npc_const", nPC, 32'hC);

      // reach PC=0x100, nPC=0x104 then branch back by one word
      Jump = 1; Jump_Target = 32'h100;
      step("jmp100");
      clear_ctl();
      step("at100");
      Branch_Taken = 1; Branch_Disp = 22'h3FFFFC;
      step("br_neg4");
      check("br.delay_slot", PC_In, 32'h104);
      clear_ctl();
      step("br_tgt");
      check("br.target", PC_In, 32'hF0);
      step("br_after");
      check("br.after", PC_In, 32'hF4);

      // annul with untaken branch
      Jump = 1; Jump_Target = 32'h20;
      step("jmp20");
      clear_ctl(); Annul = 1;
      step("annul");
      check("annul.slot_const", 32'(Annul_Slot), 32'd1);
      clear_ctl();
      step("annul_clr");

      // annul with taken branch does not squash; jump beats branch
      Annul = 1; Branch_Taken = 1; Branch_Disp = 22'd5; Jump = 1; Jump_Target = 32'h200;
      step("jmp_and_br");
      check("jmp_wins", nPC, 32'h200);
      clear_ctl();

      // stall, then trap during the stall
      Advance = 0;
      repeat (3) step("stall");
      Trap_Request = 1; Trap_Vector = 32'h800;
      step("trap");
      check("trap.pc_in_const", PC_In, 32'h804 - 4);
      Trap_Request = 0; Advance = 1;
      step("trap_issue");
      Trap_Request = 1; Trap_Vector = 32'h900; Jump = 1; Jump_Target = 32'h400;
      step("trap_vs_jump");
      check("trap_wins", nPC, 32'h904);
      step("trap_ignored");
      clear_ctl();

      // nPC wraparound
      Jump = 1; Jump_Target = 32'hFFFF_FFFC;
      step("jmp_top");
      clear_ctl();
      step("wrap");
      check("wrap.npc_const", nPC, 32'h0);

      // misaligned jump target
      Jump = 1; Jump_Target = 32'h102;
      step("misalign");
`ifdef PC_SEQ_ALIGN_CHECK_EN
      check("misalign.npc_const", nPC, 32'h80);
`else
      check("misalign.npc_const", nPC, 32'h100);
`endif
      clear_ctl();
      step("misalign_clr");

      // asynchronous reset mid-cycle
      #2 Reset = 1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge Clock);
      Reset = 0;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         Advance      = ($urandom_range(0, 3) != 0);
         Branch_Taken = ($urandom_range(0, 3) == 0);
         Jump         = ($urandom_range(0, 5) == 0);
         Annul        = $urandom_range(0, 1) == 1;
         Trap_Request = ($urandom_range(0, 15) == 0);
         Branch_Disp  = 22'($urandom);
         Jump_Target  = $urandom;
         if ($urandom_range(0, 1) == 1) Jump_Target[1:0] = 2'b00;
         Trap_Vector  = $urandom & 32'hFFFF_FFFC;
         if (i == 200) begin
            Reset = 1;
            #1;
            model_reset();
            check_all("rnd_rst");
            @(negedge Clock);
            Reset = 0;
         end
         step("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC generator for the SPARC data path. It drives the PC register's PC_In/Load_Enable pair and reads back the current PC. It keeps the architectural nPC and implements SPARC delayed control transfer: sequential flow, PC-relative branches with delay slot and annul, absolute jumps, and trap redirection. State updates on the rising edge of Clock, so the PC register captures PC_In on the following falling edge.

## Interface
- RESET_VECTOR, 32'h00000000, first instruction address after reset
- MISALIGN_VECTOR, 32'h00000080, redirect address for a misaligned target (used only with PC_SEQ_ALIGN_CHECK_EN)

- Clock  in  1  system clock, rising-edge state updates
- Reset  in  1  asynchronous, active-high
- PC  in  32  current PC from the PC register
- Advance  in  1  pipeline accepts the current instruction; 0 = stall
- Branch_Taken  in  1  resolved taken PC-relative branch (Bicc/CALL)
- Branch_Disp  in  22  word displacement, signed
- Jump  in  1  absolute transfer (JMPL/RETT)
- Jump_Target  in  32  absolute target
- Annul  in  1  annul bit of the resolving branch
- Trap_Request  in  1  level request from trap logic
- Trap_Vector  in  32  trap handler address
- PC_In  out  32  value for the PC register
- Load_Enable  out  1  PC register load strobe
- nPC  out  32  architectural next PC
- Annul_Slot  out  1  the instruction loaded with this strobe is squashed
- Trap_Ack  out  1  one-cycle pulse: trap redirect issued
- Misalign  out  1  one-cycle pulse: misaligned target redirected (0 without the macro)

## Operation
- States: BOOT, RUN, TRAP_ISSUE.
- Async Reset: state=BOOT. PC_In=0, nPC=0, Load_Enable=0, Annul_Slot=0, Trap_Ack=0, Misalign=0.
- BOOT, first edge after Reset deasserts:
  - PC_In<=RESET_VECTOR, nPC<=RESET_VECTOR+4, Load_Enable<=1.
  - Next state RUN. Advance is ignored in BOOT.
- RUN priority (highest first): Trap_Request, Jump, Branch_Taken, sequential.
- Trap_Request=1, taken regardless of Advance:
  - PC_In<=Trap_Vector, nPC<=Trap_Vector+4, Load_Enable<=1, Trap_Ack<=1, Annul_Slot<=0.
  - Next state TRAP_ISSUE.
- TRAP_ISSUE: Load_Enable<=0, Trap_Ack<=0. Next state RUN. Trap_Request is ignored for this one cycle.
- Advance=0 (no trap): Load_Enable<=0. PC_In, nPC and Annul_Slot hold.
- Advance=1, every non-trap case: PC_In<=nPC, Load_Enable<=1 (delayed transfer). nPC then updates as follows:
  - Jump: nPC<=Jump_Target.
  - Branch_Taken: nPC<=PC + (sign_ext(Branch_Disp)<<2).
  - Otherwise: nPC<=nPC+4.
- Annul, sampled only on an Advance=1 edge:
  - Annul=1 with Branch_Taken=0: Annul_Slot<=1.
  - Annul=1 with Branch_Taken=1: Annul_Slot<=0. Delay slot executes, as for SPARC conditional branches.
  - All other Advance=1 edges: Annul_Slot<=0.
- Arithmetic: all adds are 32-bit modulo 2^32. nPC 32'hFFFFFFFC + 4 wraps to 32'h00000000. The displacement is sign-extended to 32 bits before the shift.

## Timing
- PC_In and Load_Enable are registered on the rising edge and valid before the next falling edge. The PC register loads half a cycle after the sequencer decides.
- Redirect latency:
  - Branch/jump: the target reaches PC_In on the second Advance=1 edge after resolution (delay slot first).
  - Trap: the vector reaches PC_In on the same edge.
- Load_Enable is asserted at most once per Advance=1 edge and in BOOT/trap issue. It deasserts on the next edge unless Advance stays 1.
- Simultaneous Trap_Request and Jump/Branch_Taken: trap wins and the transfer is discarded.
- Simultaneous Jump and Branch_Taken: Jump wins.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronously) and re-enters BOOT.

## Configuration
- PC_SEQ_ALIGN_CHECK_EN defined:
  - Any Jump target or branch target with bits [1:0]≠0 sets nPC<=MISALIGN_VECTOR instead of the target.
  - Misalign<=1 for one cycle on that edge.
- Undefined: target bits [1:0] are forced to 00 and Misalign is tied 0.

## Test plan
- Reset, then deassert with RESET_VECTOR=0, Advance=1 for 3 edges -> PC_In 0, 0x4, 0x8; nPC 0x4, 0x8, 0xC; Load_Enable 1 each edge.
- At PC=0x100, nPC=0x104: Branch_Taken=1, Branch_Disp=22'h3FFFFC (-4) -> PC_In 0x104 (delay slot), then 0xF0, then 0xF4.
- Annul=1, Branch_Taken=0 at nPC=0x20 -> next load PC_In=0x20 with Annul_Slot=1, following load Annul_Slot=0.
- Advance=0 for 3 cycles, then Trap_Request=1, Trap_Vector=0x800 -> Load_Enable 0 during the stall. On the trap edge: PC_In=0x800, nPC=0x804, one Trap_Ack pulse. Trap and Jump asserted together -> trap wins.
- nPC=0xFFFFFFFC, Advance=1 -> PC_In=0xFFFFFFFC, nPC=0x00000000.
- With PC_SEQ_ALIGN_CHECK_EN: Jump_Target=0x102 -> nPC=0x80 and Misalign pulses once. Without the macro: nPC=0x100 and Misalign stays 0.
